draw_arbiter: RTL and testbench
===============================

// Module: draw_arbiter
// PURPOSE
//  Downstream of the on-screen button instances: collects their update requests, grants one
//  at a time via the draw/cnext/drawdone handshake, and streams its window then pixels to the
//  LCD write engine. Round-robin between requesters; one button drawn to completion at a time.
// PARAMETERS
//  NBUTTONS  4   number of attached buttons (1..16)
//  IDXBITS   2   width of grant index, >= clog2(NBUTTONS), min 1
// PORTS
//  clk        in   1            system clock
//  arst       in   1            asynchronous reset, active high
//  enable     in   1            1 = may start new grants; 0 = finish current, then hold IDLE
//  update     in   NBUTTONS     per-button redraw request
//  drawdone   in   NBUTTONS     per-button done/idle flag
//  xstart     in   16*NBUTTONS  packed window coords, button i at [16*i +: 16]
//  xend       in   16*NBUTTONS  "
//  ystart     in   16*NBUTTONS  "
//  yend       in   16*NBUTTONS  "
//  color      in   16*NBUTTONS  packed current RGB565 pixel of each button
//  draw       out  NBUTTONS     one-hot grant, registered
//  cnext      out  NBUTTONS     pixel-advance strobe to granted button (combinational)
//  win_valid  out  1            window command valid
//  win_ready  in   1            LCD engine accepts window
//  win_xs/win_xe/win_ys/win_ye  out 16 each  registered window of granted button
//  pix_valid  out  1            pixel valid (registered)
//  pix_ready  in   1            LCD engine accepts pixel
//  pix_data   out  16           color of granted button (combinational mux by grant index)
//  busy       out  1            high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; draw=0, win_valid=0, pix_valid=0, win_*=0, grant idx=0, last=NBUTTONS-1.
//  IDLE: if enable and |update: pick first i with update[i] searching from last+1 upward,
//   wrapping. Register draw=onehot(i), idx=i, win_*=button i coords,
//   npix=(xend-xstart+1)*(yend-ystart+1) as 32-bit unsigned; last<=i -> GRANT.
//  GRANT: one cycle, cnext=0 (button leaves idle, clears update) -> WIN with win_valid=1.
//  WIN: hold win_valid and win_* until win_valid&&win_ready; then win_valid=0, pix_valid=1,
//   cnt=npix -> PIX.
//  PIX: pix_valid=1; cnext[idx] = pix_valid&&pix_ready; other cnext bits always 0.
//   Each accept decrements cnt. On accept with cnt==1: same edge draw<=0, pix_valid<=0 -> DONE.
//   draw must be low the cycle after the final cnext, else the button restarts.
//  DONE: wait drawdone[idx]==1 -> IDLE. Next grant earliest the cycle after.
//  pix_ready low: hold pix_valid, no cnext, cnt unchanged; color stable (button holds pos).
//  enable low affects only IDLE; an active grant always runs to DONE.
//  update bits that rise during a grant are serviced in later IDLE passes (round-robin order).
//  Degenerate window (xend<xstart or yend<ystart): not supported; npix wraps, undefined.
//  arst mid-operation: all outputs return to reset values immediately; the LCD engine must be
//   reset by the same arst. Granted button sees draw=0 and idles once drawdone returns.
//  Latency: update -> draw 1 cycle; draw -> win_valid 1 cycle; win accept -> first pix 1 cycle.
// TESTING
//  1. update=4'b0001, btn0 8x4 @(10,20), ready tied 1 -> win (10,17,20,23), 32 pixels, 32
//     cnext[0] pulses, draw low 1 cycle after 32nd, busy low after drawdone[0].
//  2. update=4'b1111 held -> grants in order 0,1,2,3,0; never two draw bits high.
//  3. pix_ready toggled 1,0,0,1 during 2x2 button -> exactly 4 cnext, pix_data per pixel
//     matches bitmap order, no cnext while ready=0.
//  4. win_ready low 5 cycles -> win_valid and win_* stable, no cnext, pix_valid=0 throughout.
//  5. enable=0 with update=4'b0010 -> no grant; enable=1 -> draw=4'b0010 next cycle.
//  6. arst pulse mid-PIX of 16x16 -> draw=0, pix_valid=0, busy=0 immediately; after release
//     button redraws from first pixel on its next update.

Source files
------------

// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin grant of on-screen buttons to the LCD engine.
// Streams the granted button's window, then its pixels, one button at a time.
module draw_arbiter #(
  parameter int NBUTTONS = 4,
  parameter int IDXBITS  = 2
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    enable,
  input  logic [NBUTTONS-1:0]     update,
  input  logic [NBUTTONS-1:0]     drawdone,
  input  logic [16*NBUTTONS-1:0]  xstart,
  input  logic [16*NBUTTONS-1:0]  xend,
  input  logic [16*NBUTTONS-1:0]  ystart,
  input  logic [16*NBUTTONS-1:0]  yend,
  input  logic [16*NBUTTONS-1:0]  color,
  output logic [NBUTTONS-1:0]     draw,
  output logic [NBUTTONS-1:0]     cnext,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [15:0]             win_xs,
  output logic [15:0]             win_xe,
  output logic [15:0]             win_ys,
  output logic [15:0]             win_ye,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [15:0]             pix_data,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WIN,
    S_PIX,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [IDXBITS-1:0]  idx;
  logic [IDXBITS-1:0]  idx_n;
  logic [IDXBITS-1:0]  last;
  logic [IDXBITS-1:0]  last_n;
  logic [NBUTTONS-1:0] draw_n;
  logic                win_valid_n;
  logic                pix_valid_n;
  logic [15:0]         xs_n;
  logic [15:0]         xe_n;
  logic [15:0]         ys_n;
  logic [15:0]         ye_n;
  logic [31:0]         npix;
  logic [31:0]         npix_n;
  logic [31:0]         cnt;
  logic [31:0]         cnt_n;

  logic [IDXBITS-1:0]  sel;
  logic [IDXBITS-1:0]  sel_hi;
  logic [IDXBITS-1:0]  sel_lo;
  logic                sel_hi_ok;
  logic                sel_lo_ok;
  logic [NBUTTONS-1:0] sel_oh;
  logic [15:0]         sel_xs;
  logic [15:0]         sel_xe;
  logic [15:0]         sel_ys;
  logic [15:0]         sel_ye;
  logic                done_sel;
  logic                pix_fire;

  // Round-robin: lowest requester above last wins, else lowest overall.
  always_comb begin
    sel_hi    = '0;
    sel_lo    = '0;
    sel_hi_ok = 1'b0;
    sel_lo_ok = 1'b0;
    for (int j = NBUTTONS - 1; j >= 0; j--) begin
      if (update[j]) begin
        sel_lo    = IDXBITS'(j);
        sel_lo_ok = 1'b1;
        if (j > int'(last)) begin
          sel_hi    = IDXBITS'(j);
          sel_hi_ok = 1'b1;
        end
      end
    end
    sel = sel_hi_ok ? sel_hi : sel_lo;
  end

  always_comb begin
    sel_oh = '0;
    sel_xs = '0;
    sel_xe = '0;
    sel_ys = '0;
    sel_ye = '0;
    for (int j = 0; j < NBUTTONS; j++) begin
      if (sel == IDXBITS'(j)) begin
        sel_oh[j] = 1'b1;
        sel_xs    = xstart[16*j +: 16];
        sel_xe    = xend[16*j +: 16];
        sel_ys    = ystart[16*j +: 16];
        sel_ye    = yend[16*j +: 16];
      end
    end
  end

  assign pix_fire = (state == S_PIX) && pix_valid && pix_ready;

  always_comb begin
    cnext    = '0;
    pix_data = '0;
    done_sel = 1'b0;
    for (int j = 0; j < NBUTTONS; j++) begin
      if (idx == IDXBITS'(j)) begin
        cnext[j] = pix_fire;
        pix_data = color[16*j +: 16];
        done_sel = drawdone[j];
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    last_n      = last;
    draw_n      = draw;
    win_valid_n = win_valid;
    pix_valid_n = pix_valid;
    xs_n        = win_xs;
    xe_n        = win_xe;
    ys_n        = win_ys;
    ye_n        = win_ye;
    npix_n      = npix;
    cnt_n       = cnt;
    unique case (state)
      S_IDLE: begin
        if (enable && sel_lo_ok) begin
          draw_n  = sel_oh;
          idx_n   = sel;
          last_n  = sel;
          xs_n    = sel_xs;
          xe_n    = sel_xe;
          ys_n    = sel_ys;
          ye_n    = sel_ye;
          npix_n  = (32'(sel_xe) - 32'(sel_xs) + 32'd1)
                  * (32'(sel_ye) - 32'(sel_ys) + 32'd1);
          state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        win_valid_n = 1'b1;
        state_n     = S_WIN;
      end
      S_WIN: begin
        if (win_valid && win_ready) begin
          win_valid_n = 1'b0;
          pix_valid_n = 1'b1;
          cnt_n       = npix;
          state_n     = S_PIX;
        end
      end
      S_PIX: begin
        // Drop draw with the last pixel so the button does not restart.
        if (pix_fire) begin
          cnt_n = cnt - 32'd1;
          if (cnt == 32'd1) begin
            draw_n      = '0;
            pix_valid_n = 1'b0;
            state_n     = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (done_sel) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= S_IDLE;
      idx       <= '0;
      last      <= IDXBITS'(NBUTTONS - 1);
      draw      <= '0;
      win_valid <= 1'b0;
      pix_valid <= 1'b0;
      win_xs    <= '0;
      win_xe    <= '0;
      win_ys    <= '0;
      win_ye    <= '0;
      npix      <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      last      <= last_n;
      draw      <= draw_n;
      win_valid <= win_valid_n;
      pix_valid <= pix_valid_n;
      win_xs    <= xs_n;
      win_xe    <= xe_n;
      win_ys    <= ys_n;
      win_ye    <= ye_n;
      npix      <= npix_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: directed + random checks of draw_arbiter against
// a transaction-level model of buttons, round-robin order and pixel streams.
module tb_draw_arbiter;
  localparam int N  = 4;
  localparam int IB = 2;

  logic clk = 1'b0;
  logic arst;
  logic enable;
  logic [N-1:0] update;
  logic [N-1:0] drawdone;
  logic [16*N-1:0] xstart;
  logic [16*N-1:0] xend;
  logic [16*N-1:0] ystart;
  logic [16*N-1:0] yend;
  logic [16*N-1:0] color;
  logic [N-1:0] draw;
  logic [N-1:0] cnext;
  logic win_valid;
  logic win_ready;
  logic [15:0] win_xs;
  logic [15:0] win_xe;
  logic [15:0] win_ys;
  logic [15:0] win_ye;
  logic pix_valid;
  logic pix_ready;
  logic [15:0] pix_data;
  logic busy;

  int checks = 0;
  int errors = 0;
  int xs[N];
  int xe[N];
  int ys[N];
  int ye[N];
  int pos[N];
  bit bbusy[N];
  bit hold_upd;
  int exp_last;

  draw_arbiter #(.NBUTTONS(N), .IDXBITS(IB)) dut (
    .clk(clk), .arst(arst), .enable(enable),
    .update(update), .drawdone(drawdone),
    .xstart(xstart), .xend(xend), .ystart(ystart), .yend(yend),
    .color(color), .draw(draw), .cnext(cnext),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_xs(win_xs), .win_xe(win_xe), .win_ys(win_ys), .win_ye(win_ye),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] col(input int i, input int k);
    return 16'((i << 12) ^ (k * 37 + 5));
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  function automatic int pick(input int lst, input logic [N-1:0] u);
    int r;
    int j;
    r = -1;
    for (int k = 1; k <= N; k++) begin
      j = (lst + k) % N;
      if (r < 0 && u[j]) r = j;
    end
    return r;
  endfunction

  task automatic pack_coords();
    for (int i = 0; i < N; i++) begin
      xstart[16*i +: 16] = 16'(xs[i]);
      xend[16*i +: 16]   = 16'(xe[i]);
      ystart[16*i +: 16] = 16'(ys[i]);
      yend[16*i +: 16]   = 16'(ye[i]);
    end
  endtask

  // Button model: leaves idle on draw, advances on cnext, idles on draw low.
  task automatic btn_update();
    for (int i = 0; i < N; i++) begin
      if (draw[i] && !bbusy[i]) begin
        bbusy[i] = 1'b1;
        drawdone[i] = 1'b0;
        pos[i] = 0;
        if (!hold_upd) update[i] = 1'b0;
      end else if (!draw[i] && bbusy[i]) begin
        bbusy[i] = 1'b0;
        drawdone[i] = 1'b1;
      end
      if (cnext[i]) pos[i]++;
      color[16*i +: 16] = col(i, pos[i]);
    end
  endtask

  task automatic tick(input logic wr, input logic pr);
    btn_update();
    @(negedge clk);
    win_ready = wr;
    pix_ready = pr;
    #1;
  endtask

  task automatic run_grant(input int pmode, input int wdelay,
                           input int abort_at, output int gout);
    int g;
    int n;
    int acc;
    int wv;
    int pk;
    int ph;
    int cyc;
    logic wr;
    logic pr;
    logic [3:0] pat;
    logic [N-1:0] ohg;
    pat = 4'b1001;
    g = pick(exp_last, update);
    gout = g;
    if (g < 0) begin
      checks++;
      errors++;
      $error("FAIL pick: got none expected a requester");
      return;
    end
    exp_last = g;
    ohg = oh(g);
    n = (xe[g] - xs[g] + 1) * (ye[g] - ys[g] + 1);
    tick(1'b0, 1'b0);
    chk("grant_draw", draw, ohg);
    chk("grant_cnext", cnext, 0);
    chk("grant_busy", busy, 1);
    acc = 0; wv = 0; pk = 0; ph = 0; cyc = 0;
    while (ph < 3 && cyc < 3000) begin
      cyc++;
      wr = (ph == 0) && (wv >= wdelay);
      pr = 1'b0;
      if (ph == 1) begin
        if (pmode == 0) pr = 1'b1;
        else if (pmode == 1) pr = pat[pk % 4];
        else pr = 1'($urandom_range(0, 1));
        pk++;
      end
      tick(wr, pr);
      chk("onehot_draw", $countones(draw) <= 1, 1);
      if (ph == 0) begin
        chk("win_valid", win_valid, 1);
        chk("win_xs", win_xs, xs[g]);
        chk("win_xe", win_xe, xe[g]);
        chk("win_ys", win_ys, ys[g]);
        chk("win_ye", win_ye, ye[g]);
        chk("win_pixv", pix_valid, 0);
        chk("win_cnext", cnext, 0);
        wv++;
        if (wr) ph = 1;
      end else if (ph == 1) begin
        chk("pix_valid", pix_valid, 1);
        chk("pix_winv", win_valid, 0);
        chk("pix_draw", draw, ohg);
        if (pr) begin
          chk("pix_cnext", cnext, ohg);
          chk("pix_data", pix_data, col(g, acc));
          acc++;
          if (acc == n) ph = 2;
        end else begin
          chk("pix_hold_cnext", cnext, 0);
        end
        if (abort_at > 0 && acc == abort_at) begin
          arst = 1'b1;
          #1;
          chk("rst_draw", draw, 0);
          chk("rst_pixv", pix_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_winv", win_valid, 0);
          chk("rst_cnext", cnext, 0);
          tick(1'b0, 1'b0);
          tick(1'b0, 1'b0);
          arst = 1'b0;
          exp_last = N - 1;
          return;
        end
      end else begin
        chk("done_draw", draw, 0);
        chk("done_pixv", pix_valid, 0);
        chk("done_cnext", cnext, 0);
        chk("done_busy", busy, 1);
        ph = 3;
      end
    end
    if (ph != 3) begin
      checks++;
      errors++;
      $error("FAIL timeout: got phase %0d expected 3", ph);
    end
    chk("win_cycles", wv, wdelay + 1);
    chk("pix_count", acc, n);
    cyc = 0;
    while (busy !== 1'b0 && cyc < 20) begin
      tick(1'b0, 1'b0);
      cyc++;
    end
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int g;
    arst = 1'b1; enable = 1'b0; update = '0; drawdone = '1;
    win_ready = 1'b0; pix_ready = 1'b0; hold_upd = 1'b0;
    for (int i = 0; i < N; i++) begin
      xs[i] = 0; xe[i] = 0; ys[i] = 0; ye[i] = 0;
      pos[i] = 0; bbusy[i] = 1'b0;
      color[16*i +: 16] = col(i, 0);
    end
    pack_coords();
    exp_last = N - 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_draw0", draw, 0);
    chk("rst_winv0", win_valid, 0);
    chk("rst_pixv0", pix_valid, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_winxs0", win_xs, 0);
    chk("rst_winye0", win_ye, 0);
    chk("rst_cnext0", cnext, 0);
    arst = 1'b0;
    enable = 1'b1;
    tick(1'b0, 1'b0);
    chk("idle_no_req", busy, 0);

    // single 8x4 button
    xs[0] = 10; xe[0] = 17; ys[0] = 20; ye[0] = 23;
    pack_coords();
    update = 4'b0001;
    run_grant(0, 0, 0, g);
    chk("t1_grant", g, 0);

    // all requesting, held: order 0,1,2,3,0 from reset
    arst = 1'b1;
    #1;
    arst = 1'b0;
    exp_last = N - 1;
    for (int i = 0; i < N; i++) begin
      xs[i] = i * 10; xe[i] = i * 10 + i; ys[i] = i; ye[i] = i + 1;
    end
    pack_coords();
    hold_upd = 1'b1;
    update = '1;
    for (int k = 0; k < 5; k++) begin
      run_grant(0, 1, 0, g);
      chk("t2_order", g, k % N);
    end
    hold_upd = 1'b0;
    update = '0;

    // 2x2 with ready pattern 1,0,0,1
    xs[2] = 5; xe[2] = 6; ys[2] = 7; ye[2] = 8;
    pack_coords();
    update = 4'b0100;
    run_grant(1, 0, 0, g);
    chk("t3_grant", g, 2);

    // window back-pressure for 5 cycles
    xs[1] = 30; xe[1] = 32; ys[1] = 40; ye[1] = 41;
    pack_coords();
    update = 4'b0010;
    run_grant(0, 5, 0, g);
    chk("t4_grant", g, 1);

    // enable gating
    enable = 1'b0;
    update = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0);
      chk("t5_nodraw", draw, 0);
      chk("t5_idle", busy, 0);
    end
    enable = 1'b1;
    run_grant(0, 0, 0, g);
    chk("t5_grant", g, 1);

    // reset mid-stream of a 16x16, then full redraw
    xs[3] = 100; xe[3] = 115; ys[3] = 50; ye[3] = 65;
    pack_coords();
    update = 4'b1000;
    run_grant(0, 0, 40, g);
    tick(1'b0, 1'b0);
    chk("t6_post_idle", busy, 0);
    chk("t6_post_draw", draw, 0);
    update = 4'b1000;
    run_grant(0, 0, 0, g);
    chk("t6_grant", g, 3);

    // random windows, requests and back-pressure
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = $urandom_range(0, 500);
        xe[i] = xs[i] + $urandom_range(0, 3);
        ys[i] = $urandom_range(0, 300);
        ye[i] = ys[i] + $urandom_range(0, 3);
      end
      pack_coords();
      update = update | N'($urandom_range(0, (1 << N) - 1));
      if (update == '0) update[$urandom_range(0, N - 1)] = 1'b1;
      run_grant($urandom_range(0, 2), $urandom_range(0, 3), 0, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
